// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_ctrl
// Description : Memory-stage access controller. Issues loads and stores from
//               the EX/MEM pipeline register to a multi-cycle backing memory
//               over a req/ack handshake, formats store byte lanes, aligns and
//               extends load data, stalls the pipeline while the access is
//               outstanding, and flags misaligned accesses and bus timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [ADDRESS_WIDTH-1:0] alu_resultM_i,
  input  logic [DATA_WIDTH-1:0]    write_dataM_i,
  input  logic                     mem_writeM_i,
  input  logic [1:0]               result_srcM_i,
  input  logic [2:0]               funct3M_i,
  output logic [DATA_WIDTH-1:0]    read_dataM_o,
  output logic                     stall_o,
  output logic                     misaligned_o,
  output logic                     bus_err_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]    mem_wdata_o,
  output logic [3:0]               mem_wstrb_o,
  input  logic                     mem_ack_i,
  input  logic [DATA_WIDTH-1:0]    mem_rdata_i
);

  // Counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] busy_cnt;

  // Load formatting context captured when the access is accepted.
  logic [1:0] lane_off;
  logic       ld_byte;
  logic       ld_half;
  logic       ld_signed;

  // Decoded view of the current M-stage instruction.
  logic                  access;
  logic                  is_store;
  logic                  size_byte;
  logic                  size_half;
  logic                  size_word;
  logic [1:0]            offset;
  logic                  misaligned;
  logic [DATA_WIDTH-1:0] fmt_wdata;
  logic [3:0]            fmt_wstrb;

  // Load data path out of the memory word.
  logic [DATA_WIDTH-1:0] lane_data;
  logic [DATA_WIDTH-1:0] fmt_rdata;

  // Decode the M-stage control into size, alignment and store lane formatting.
  always_comb begin
    access     = mem_writeM_i | (result_srcM_i == 2'b01);
    is_store   = mem_writeM_i;
    size_byte  = (funct3M_i[1:0] == 2'b00);
    size_half  = (funct3M_i[1:0] == 2'b01);
    // 010 and the unsupported 011/110/111 encodings all behave as words.
    size_word  = ~size_byte & ~size_half;
    offset     = alu_resultM_i[1:0];
    misaligned = (size_half & offset[0]) | (size_word & (offset != 2'b00));
    fmt_wdata  = write_dataM_i;
    fmt_wstrb  = 4'b1111;
    if (size_byte) begin
      fmt_wdata = {4{write_dataM_i[7:0]}};
      fmt_wstrb = 4'b0001 << offset;
    end else if (size_half) begin
      fmt_wdata = {2{write_dataM_i[15:0]}};
      fmt_wstrb = offset[1] ? 4'b1100 : 4'b0011;
    end
  end

  // Pick the addressed lane of the returned word and extend it to full width.
  always_comb begin
    lane_data = mem_rdata_i >> {lane_off, 3'b000};
    fmt_rdata = mem_rdata_i;
    if (ld_byte) begin
      fmt_rdata = {{24{ld_signed & lane_data[7]}}, lane_data[7:0]};
    end else if (ld_half) begin
      fmt_rdata = {{16{ld_signed & lane_data[15]}}, lane_data[15:0]};
    end
  end

  // The pipeline is held while an aligned access is being launched or is in flight.
  always_comb begin
    stall_o = 1'b0;
    case (state)
      IDLE:    stall_o = access & ~misaligned;
      BUSY:    stall_o = 1'b1;
      default: stall_o = 1'b0;
    endcase
  end

  // Access sequencer: launch, wait for ack or timeout, then release the pipeline.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      busy_cnt     <= '0;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      mem_wstrb_o  <= 4'b0000;
      read_dataM_o <= '0;
      misaligned_o <= 1'b0;
      bus_err_o    <= 1'b0;
      lane_off     <= 2'b00;
      ld_byte      <= 1'b0;
      ld_half      <= 1'b0;
      ld_signed    <= 1'b0;
    end else begin
      misaligned_o <= 1'b0;
      bus_err_o    <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            if (misaligned) begin
              // Dropped without touching memory; the pipeline is not held.
              misaligned_o <= 1'b1;
              read_dataM_o <= '0;
            end else begin
              mem_req_o   <= 1'b1;
              mem_we_o    <= is_store;
              mem_addr_o  <= {alu_resultM_i[ADDRESS_WIDTH-1:2], 2'b00};
              mem_wdata_o <= fmt_wdata;
              mem_wstrb_o <= fmt_wstrb;
              lane_off    <= offset;
              ld_byte     <= size_byte;
              ld_half     <= size_half;
              ld_signed   <= ~funct3M_i[2];
              busy_cnt    <= '0;
              state       <= BUSY;
            end
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            // Ack takes priority over a coincident timeout.
            mem_req_o    <= 1'b0;
            read_dataM_o <= mem_we_o ? '0 : fmt_rdata;
            state        <= DONE;
          end else if (busy_cnt == CNT_LAST) begin
            mem_req_o    <= 1'b0;
            read_dataM_o <= '0;
            bus_err_o    <= 1'b1;
            state        <= DONE;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
        end
        DONE: begin
          // The access still visible here is the one just completed.
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_ctrl
// Description : Self-checking bench for mem_stage_ctrl. Directed cases from the
//               access behaviour plus randomized accesses checked against a
//               byte-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_ctrl;

  localparam int TMO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] alu_resultM_i;
  logic [31:0] write_dataM_i;
  logic        mem_writeM_i;
  logic [1:0]  result_srcM_i;
  logic [2:0]  funct3M_i;
  logic [31:0] read_dataM_o;
  logic        stall_o;
  logic        misaligned_o;
  logic        bus_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  int total = 0;
  int bad   = 0;

  mem_stage_ctrl #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .alu_resultM_i(alu_resultM_i),
    .write_dataM_i(write_dataM_i),
    .mem_writeM_i (mem_writeM_i),
    .result_srcM_i(result_srcM_i),
    .funct3M_i    (funct3M_i),
    .read_dataM_o (read_dataM_o),
    .stall_o      (stall_o),
    .misaligned_o (misaligned_o),
    .bus_err_o    (bus_err_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_wstrb_o  (mem_wstrb_o),
    .mem_ack_i    (mem_ack_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int size_bytes(input logic [2:0] f);
    case (f)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic bit is_misal(input logic [2:0] f, input logic [31:0] a);
    int off = int'(a[1:0]);
    return (off % size_bytes(f)) != 0;
  endfunction

  function automatic logic [3:0] exp_wstrb(input logic [2:0] f, input logic [31:0] a);
    int sz  = size_bytes(f);
    int off = int'(a[1:0]);
    int m   = ((1 << sz) - 1) << off;
    return m[3:0];
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f, input logic [31:0] d);
    int sz = size_bytes(f);
    if (sz == 1) return {24'h0, d[7:0]} * 32'h01010101;
    if (sz == 2) return {16'h0, d[15:0]} * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] rd);
    int     sz  = size_bytes(f);
    int     off = int'(a[1:0]);
    longint v;
    longint span;
    if (sz == 4) return rd;
    span = longint'(1) << (8 * sz);
    v = longint'(rd >> (8 * off)) % span;
    if (f[2] == 1'b0 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  task automatic clear_inputs();
    mem_writeM_i  = 1'b0;
    result_srcM_i = 2'b00;
    funct3M_i     = 3'b000;
    alu_resultM_i = 32'h0;
    write_dataM_i = 32'h0;
  endtask

  // Presents one M-stage instruction (called just after a rising edge) and
  // follows it through to the first idle cycle afterwards. ack_after is the
  // BUSY cycle on which ack is given; beyond TMO means no ack at all.
  task automatic run_access(input bit we, input logic [1:0] rs, input logic [2:0] f,
                            input logic [31:0] a, input logic [31:0] d,
                            input int ack_after, input logic [31:0] rd);
    bit acc = we || (rs == 2'b01);
    bit mis = acc && is_misal(f, a);
    bit tmo = (ack_after > TMO);
    int nb  = tmo ? TMO : ack_after;
    mem_writeM_i  = we;
    result_srcM_i = rs;
    funct3M_i     = f;
    alu_resultM_i = a;
    write_dataM_i = d;
    mem_ack_i     = 1'b0;
    @(negedge clk_i);
    check("idle_stall", stall_o, acc && !mis);
    check("idle_req", mem_req_o, 1'b0);
    @(posedge clk_i); #1;
    if (!acc) begin
      clear_inputs();
      @(negedge clk_i);
      check("noacc_req", mem_req_o, 1'b0);
      check("noacc_mis", misaligned_o, 1'b0);
      @(posedge clk_i); #1;
      return;
    end
    if (mis) begin
      clear_inputs();
      @(negedge clk_i);
      check("mis_pulse", misaligned_o, 1'b1);
      check("mis_rdata", read_dataM_o, 32'h0);
      check("mis_req", mem_req_o, 1'b0);
      check("mis_stall", stall_o, 1'b0);
      @(posedge clk_i); #1;
      @(negedge clk_i);
      check("mis_pulse_end", misaligned_o, 1'b0);
      check("mis_req2", mem_req_o, 1'b0);
      @(posedge clk_i); #1;
      return;
    end
    for (int b = 1; b <= nb; b++) begin
      if (!tmo && b == nb) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = rd;
      end else begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = $urandom;
      end
      @(negedge clk_i);
      check("busy_req", mem_req_o, 1'b1);
      check("busy_stall", stall_o, 1'b1);
      check("busy_we", mem_we_o, we);
      check("busy_addr", mem_addr_o, {a[31:2], 2'b00});
      check("busy_err", bus_err_o, 1'b0);
      if (we) begin
        check("busy_wstrb", mem_wstrb_o, exp_wstrb(f, a));
        check("busy_wdata", mem_wdata_o, exp_wdata(f, d));
      end
      @(posedge clk_i); #1;
      mem_ack_i = 1'b0;
    end
    @(negedge clk_i);
    check("done_stall", stall_o, 1'b0);
    check("done_req", mem_req_o, 1'b0);
    check("done_buserr", bus_err_o, tmo);
    check("done_rdata", read_dataM_o, (tmo || we) ? 32'h0 : exp_load(f, a, rd));
    @(posedge clk_i); #1;
    clear_inputs();
    mem_ack_i   = 1'($urandom_range(0, 1));
    mem_rdata_i = $urandom;
    @(negedge clk_i);
    check("post_stall", stall_o, 1'b0);
    check("post_req", mem_req_o, 1'b0);
    check("post_buserr", bus_err_o, 1'b0);
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
  endtask

  initial begin
    rst_i       = 1'b1;
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;
    clear_inputs();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_req", mem_req_o, 1'b0);
    check("rst_we", mem_we_o, 1'b0);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_wdata", mem_wdata_o, 32'h0);
    check("rst_wstrb", mem_wstrb_o, 4'h0);
    check("rst_rdata", read_dataM_o, 32'h0);
    check("rst_mis", misaligned_o, 1'b0);
    check("rst_err", bus_err_o, 1'b0);
    check("rst_stall", stall_o, 1'b0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Directed cases.
    run_access(1'b0, 2'b01, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF);
    run_access(1'b1, 2'b00, 3'b000, 32'h203, 32'h000000A5, 1, 32'h0);
    run_access(1'b0, 2'b01, 3'b000, 32'h1, 32'h0, 1, 32'h80F17F01);
    run_access(1'b0, 2'b01, 3'b000, 32'h2, 32'h0, 2, 32'h80F17F01);
    run_access(1'b0, 2'b01, 3'b101, 32'h2, 32'h0, 1, 32'h80F17F01);
    run_access(1'b0, 2'b01, 3'b001, 32'h2, 32'h0, 1, 32'h80F17F01);
    run_access(1'b0, 2'b01, 3'b010, 32'h102, 32'h0, 1, 32'h0);
    run_access(1'b1, 2'b00, 3'b001, 32'h101, 32'h1234, 1, 32'h0);
    run_access(1'b0, 2'b01, 3'b010, 32'h40, 32'h0, 99, 32'h0);
    run_access(1'b0, 2'b01, 3'b010, 32'h44, 32'h0, TMO, 32'h13579BDF);
    run_access(1'b1, 2'b01, 3'b001, 32'h82, 32'hCAFEBABE, 2, 32'hFFFFFFFF);

    // Reset while the request is outstanding.
    mem_writeM_i  = 1'b0;
    result_srcM_i = 2'b01;
    funct3M_i     = 3'b010;
    alu_resultM_i = 32'h300;
    @(negedge clk_i);
    check("rm_idle_stall", stall_o, 1'b1);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("rm_busy_req", mem_req_o, 1'b1);
    rst_i = 1'b1;
    clear_inputs();
    @(posedge clk_i); #1;
    rst_i       = 1'b0;
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h55AA55AA;
    @(negedge clk_i);
    check("rm_req_drop", mem_req_o, 1'b0);
    check("rm_stall", stall_o, 1'b0);
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    check("rm_late_ack_rdata", read_dataM_o, 32'h0);
    check("rm_late_ack_req", mem_req_o, 1'b0);
    @(posedge clk_i); #1;

    // Randomized accesses.
    for (int i = 0; i < 80; i++) begin
      int          kind = $urandom_range(0, 9);
      bit          we;
      logic [1:0]  rs;
      logic [31:0] a = $urandom;
      if (kind < 4) begin
        we = 1'b1;
        rs = 2'($urandom_range(0, 3));
      end else if (kind < 8) begin
        we = 1'b0;
        rs = 2'b01;
      end else begin
        we = 1'b0;
        rs = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b11;
      end
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      run_access(we, rs, 3'($urandom_range(0, 7)), a, $urandom,
                 $urandom_range(1, TMO + 2), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
